// File: rtl/glitch_filter_pkg.sv
// Shared definitions for the multi-channel glitch filter.
//   state_e     : per-channel filter FSM state
//   MODE_*      : per-channel filter mode encodings
//   qual_cnt_w  : width of the qualifier counter for a given filter length
package glitch_filter_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_e;

    localparam logic MODE_SYM  = 1'b0;  // both edges qualified
    localparam logic MODE_FAST = 1'b1;  // assert edge immediate, deassert qualified

    // The counter only has to reach FILT_CYCLES-1, so $clog2(FILT_CYCLES)
    // bits suffice; keep at least one bit for the degenerate small case.
    function automatic int qual_cnt_w(input int filt_cycles);
        return (filt_cycles <= 2) ? 1 : $clog2(filt_cycles);
    endfunction

endpackage

// File: rtl/glitch_filter_ch.sv
// One filter channel: synchroniser chain, STABLE/QUALIFY filter FSM,
// registered edge strobes and a saturating rejected-glitch counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   din          : raw asynchronous input
//   mode         : MODE_SYM / MODE_FAST, sampled only while STABLE
//   glitch_clr   : synchronous clear of the glitch counter (wins over +1)
//   dout         : filtered output
//   rise, fall   : one-cycle strobes, high the cycle after dout changes
//   glitch_cnt   : saturating count of rejected pulses
//   qualifying   : debug view of the FSM (1 = ST_QUALIFY)
module glitch_filter_ch
    import glitch_filter_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   FILT_CYCLES  = 4,
    parameter int   GLITCH_CNT_W = 8,
    parameter logic RST_VAL      = 1'b0,
    parameter logic ASSERT_LVL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din,
    input  logic                    mode,
    input  logic                    glitch_clr,
    output logic                    dout,
    output logic                    rise,
    output logic                    fall,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt,
    output logic                    qualifying
);

    localparam int            QW       = qual_cnt_w(FILT_CYCLES);
    localparam logic [QW-1:0] CNT_LAST = QW'(FILT_CYCLES - 1);
    localparam logic [QW-1:0] CNT_ONE  = QW'(1);

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    s;
    state_e                  state_q;
    logic [QW-1:0]           cnt_q;
    logic                    dout_q;
    logic                    rise_q;
    logic                    fall_q;
    logic [GLITCH_CNT_W-1:0] gcnt_q;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (glitch_clr) begin
                gcnt_q <= '0;
            end

            case (state_q)
                ST_STABLE: begin
                    if (s != dout_q) begin
                        if (mode == MODE_FAST && s == ASSERT_LVL) begin
                            // Assert level passes straight through.
                            dout_q <= s;
                            rise_q <= s;
                            fall_q <= ~s;
                        end else begin
                            state_q <= ST_QUALIFY;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end

                ST_QUALIFY: begin
                    if (s == dout_q) begin
                        // Input fell back before qualifying: a glitch.
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                        if (!glitch_clr && gcnt_q != '1) begin
                            gcnt_q <= gcnt_q + GLITCH_CNT_W'(1);
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        dout_q  <= s;
                        rise_q  <= s;
                        fall_q  <= ~s;
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign glitch_cnt = gcnt_q;
    assign qualifying = (state_q == ST_QUALIFY);

endmodule

// File: rtl/glitch_filter_multi.sv
// Multi-channel glitch filter: NUM_CH independent glitch_filter_ch
// instances with per-channel reset value and assert level.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   din          : raw inputs, one bit per channel
//   mode         : per channel 0 = symmetric, 1 = fast-assert
//   glitch_clr   : clears every glitch counter
//   dout         : filtered outputs
//   rise, fall   : per-channel one-cycle edge strobes
//   glitch_cnt   : channel i at [i*GLITCH_CNT_W +: GLITCH_CNT_W]
//   state        : debug, per channel 1 = qualifying an edge
module glitch_filter_multi
    import glitch_filter_pkg::*;
#(
    parameter int                NUM_CH       = 4,
    parameter int                SYNC_STAGES  = 2,
    parameter int                FILT_CYCLES  = 4,
    parameter int                GLITCH_CNT_W = 8,
    parameter logic [NUM_CH-1:0] RST_VAL      = {NUM_CH{1'b0}},
    parameter logic [NUM_CH-1:0] ASSERT_LVL   = {NUM_CH{1'b0}}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              din,
    input  logic [NUM_CH-1:0]              mode,
    input  logic                           glitch_clr,
    output logic [NUM_CH-1:0]              dout,
    output logic [NUM_CH-1:0]              rise,
    output logic [NUM_CH-1:0]              fall,
    output logic [NUM_CH*GLITCH_CNT_W-1:0] glitch_cnt,
    output logic [NUM_CH-1:0]              state
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        glitch_filter_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILT_CYCLES  (FILT_CYCLES),
            .GLITCH_CNT_W (GLITCH_CNT_W),
            .RST_VAL      (RST_VAL[i]),
            .ASSERT_LVL   (ASSERT_LVL[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .din        (din[i]),
            .mode       (mode[i]),
            .glitch_clr (glitch_clr),
            .dout       (dout[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .glitch_cnt (glitch_cnt[i*GLITCH_CNT_W +: GLITCH_CNT_W]),
            .qualifying (state[i])
        );
    end

endmodule

// File: tb/tb_glitch_filter_multi.sv
// Directed testbench for glitch_filter_multi with a run-length based
// reference model and per-cycle comparison of every output.
module tb_glitch_filter_multi;

    localparam int              NUM_CH = 4;
    localparam int              SYNC   = 2;
    localparam int              FILT   = 4;
    localparam int              W      = 8;
    localparam logic [NUM_CH-1:0] RSTV = 4'b0010;
    localparam logic [NUM_CH-1:0] ALVL = 4'b0000;

    logic                  clk;
    logic                  rst;
    logic [NUM_CH-1:0]     din;
    logic [NUM_CH-1:0]     mode;
    logic                  glitch_clr;
    logic [NUM_CH-1:0]     dout;
    logic [NUM_CH-1:0]     rise;
    logic [NUM_CH-1:0]     fall;
    logic [NUM_CH*W-1:0]   glitch_cnt;
    logic [NUM_CH-1:0]     state;

    int checks = 0;
    int errors = 0;

    glitch_filter_multi #(
        .NUM_CH       (NUM_CH),
        .SYNC_STAGES  (SYNC),
        .FILT_CYCLES  (FILT),
        .GLITCH_CNT_W (W),
        .RST_VAL      (RSTV),
        .ASSERT_LVL   (ALVL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .mode       (mode),
        .glitch_clr (glitch_clr),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .glitch_cnt (glitch_cnt),
        .state      (state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // s is din delayed by SYNC edges; run counts consecutive edges at which
    // the synchronised value differed from the output.
    logic              hist [NUM_CH][SYNC];
    logic [NUM_CH-1:0] m_dout, m_rise, m_fall, m_qual;
    int                run  [NUM_CH];
    int                m_gc [NUM_CH];
    bit                model_valid = 0;

    logic [NUM_CH-1:0] din_c, mode_c;
    logic              rst_c, clr_c;

    task automatic model_step();
        logic s_old, prev;
        bit   glitch;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_c) begin
                for (int k = 0; k < SYNC; k++) hist[c][k] = RSTV[c];
                m_dout[c] = RSTV[c];
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                run[c]    = 0;
                m_gc[c]   = 0;
            end else begin
                s_old = hist[c][SYNC-1];
                for (int k = SYNC-1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = din_c[c];
                prev   = m_dout[c];
                glitch = 0;
                if (run[c] == 0) begin
                    if (s_old != prev) begin
                        if (mode_c[c] && s_old == ALVL[c]) m_dout[c] = s_old;
                        else run[c] = 1;
                    end
                end else if (s_old == prev) begin
                    glitch = 1;
                    run[c] = 0;
                end else begin
                    run[c]++;
                    if (run[c] == FILT) begin
                        m_dout[c] = s_old;
                        run[c]    = 0;
                    end
                end
                m_rise[c] = !prev && m_dout[c];
                m_fall[c] = prev && !m_dout[c];
                if (clr_c) m_gc[c] = 0;
                else if (glitch && m_gc[c] < (1 << W) - 1) m_gc[c]++;
            end
            m_qual[c] = (run[c] != 0);
        end
        if (rst_c) model_valid = 1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic [NUM_CH*W-1:0] e_gc;
    always @(posedge clk) begin
        din_c  = din;
        mode_c = mode;
        rst_c  = rst;
        clr_c  = glitch_clr;
        #1;
        model_step();
        if (model_valid) begin
            for (int c = 0; c < NUM_CH; c++) e_gc[c*W +: W] = W'(m_gc[c]);
            cmp("cyc_dout",  32'(dout),       32'(m_dout));
            cmp("cyc_rise",  32'(rise),       32'(m_rise));
            cmp("cyc_fall",  32'(fall),       32'(m_fall));
            cmp("cyc_state", 32'(state),      32'(m_qual));
            cmp("cyc_gcnt",  32'(glitch_cnt), 32'(e_gc));
        end
    end

    function automatic logic [W-1:0] gc(input int c);
        return glitch_cnt[c*W +: W];
    endfunction

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pos1(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst        = 1'b1;
        din        = '0;
        mode       = '0;
        glitch_clr = 1'b0;

        // 1: reset with din toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din = 4'($urandom_range(0, 15));
            cmp("rst_dout", 32'(dout), 32'(RSTV));
            cmp("rst_strobe", 32'({rise, fall}), 32'h0);
            cmp("rst_gcnt", 32'(glitch_cnt), 32'h0);
        end
        @(negedge clk);
        rst  = 1'b0;
        din  = RSTV;
        mode = 4'b0010;
        negs(4);
        cmp("rel_dout", 32'(dout), 32'(RSTV));
        cmp("rel_gcnt", 32'(glitch_cnt), 32'h0);

        // 2: ch0 symmetric: 3-cycle pulse rejected, held level passes
        din[0] = 1'b1;
        negs(3);
        din[0] = 1'b0;
        negs(8);
        cmp("t2_reject_dout", 32'(dout[0]), 32'h0);
        cmp("t2_reject_gcnt", 32'(gc(0)), 32'h1);
        din[0] = 1'b1;
        pos1(5);
        cmp("t2_rise_edge5", 32'(dout[0]), 32'h0);
        pos1(1);
        cmp("t2_rise_edge6", 32'({dout[0], rise[0]}), 32'h3);
        pos1(1);
        cmp("t2_rise_once", 32'(rise[0]), 32'h0);
        @(negedge clk);
        din[0] = 1'b0;
        pos1(5);
        cmp("t2_fall_edge5", 32'(dout[0]), 32'h1);
        pos1(1);
        cmp("t2_fall_edge6", 32'({dout[0], fall[0]}), 32'h1);
        negs(2);

        // 3: ch1 fast-assert (assert level 0, reset value 1)
        din[1] = 1'b0;
        @(negedge clk);
        din[1] = 1'b1;
        pos1(2);
        cmp("t3_fast_edge3", 32'({dout[1], fall[1]}), 32'h1);
        pos1(3);
        cmp("t3_deassert_edge6", 32'(dout[1]), 32'h0);
        pos1(1);
        cmp("t3_deassert_edge7", 32'({dout[1], rise[1]}), 32'h3);
        @(negedge clk);
        din[1] = 1'b0;
        negs(6);
        cmp("t3_low_again", 32'(dout[1]), 32'h0);
        din[1] = 1'b1;
        negs(2);
        din[1] = 1'b0;
        negs(8);
        cmp("t3_blip_dout", 32'(dout[1]), 32'h0);
        cmp("t3_blip_gcnt", 32'(gc(1)), 32'h1);

        // 4: saturate ch2 counter
        for (int i = 0; i < 300; i++) begin
            din[2] = 1'b1;
            negs(2);
            din[2] = 1'b0;
            negs(4);
        end
        negs(4);
        cmp("t4_sat_ch2", 32'(gc(2)), 32'd255);
        cmp("t4_ch0", 32'(gc(0)), 32'd1);
        cmp("t4_ch1", 32'(gc(1)), 32'd1);
        cmp("t4_ch3", 32'(gc(3)), 32'd0);

        // 5: clear coincident with a ch3 rejection
        din[3] = 1'b1;
        negs(2);
        din[3] = 1'b0;
        negs(6);
        cmp("t5_ch3_one", 32'(gc(3)), 32'd1);
        din[3] = 1'b1;
        negs(2);
        din[3] = 1'b0;
        negs(2);
        glitch_clr = 1'b1;
        negs(1);
        glitch_clr = 1'b0;
        negs(2);
        cmp("t5_clr_ch3", 32'(gc(3)), 32'd0);
        cmp("t5_clr_ch2", 32'(gc(2)), 32'd0);
        din[3] = 1'b1;
        negs(2);
        din[3] = 1'b0;
        negs(6);
        cmp("t5_after_clr", 32'(gc(3)), 32'd1);

        // 6: reset mid-qualification on ch0
        din[0] = 1'b1;
        negs(4);
        cmp("t6_qualifying", 32'(state[0]), 32'h1);
        rst    = 1'b1;
        din[0] = 1'b0;
        negs(2);
        cmp("t6_rst_dout", 32'(dout[0]), 32'(RSTV[0]));
        cmp("t6_rst_strobe", 32'({rise[0], fall[0]}), 32'h0);
        rst = 1'b0;
        negs(8);
        cmp("t6_post_dout", 32'(dout[0]), 32'h0);
        cmp("t6_post_gcnt", 32'(gc(0)), 32'h0);
        cmp("t6_post_state", 32'(state[0]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glitch_filter_multi.md
Name: glitch_filter_multi

Overview:
Multi-channel, parametrised successor to the single-bit glitch-free input filter. Each channel first synchronises an asynchronous or noisy input (typically an external reset or strap), then filters it with a per-channel qualification counter. An edge moves to the output only after the input has held its new level for FILT_CYCLES consecutive cycles. Adds a per-channel fast-assert mode, one-cycle edge strobes, and saturating rejected-glitch counters for debug/CSR readout.

Parameters:
NUM_CH, 4, number of independent channels.
SYNC_STAGES, 2, synchroniser flops per channel (>=2).
FILT_CYCLES, 4, consecutive cycles a new level must persist to propagate (>=2).
GLITCH_CNT_W, 8, width of each rejected-glitch counter.
RST_VAL, {NUM_CH{1'b0}}, per-channel reset value of synchroniser and output.
ASSERT_LVL, {NUM_CH{1'b0}}, per-channel level treated as "assert" in fast-assert mode.

Ports:
clk  in  1  single clock for the block.
rst  in  1  synchronous reset, active-high.
din  in  NUM_CH  raw asynchronous/noisy inputs.
mode  in  NUM_CH  per channel: 0 = symmetric filter, 1 = fast-assert/filtered-deassert.
glitch_clr  in  1  synchronous clear of all glitch counters.
dout  out  NUM_CH  filtered outputs.
rise  out  NUM_CH  one-cycle strobe when dout goes 0->1.
fall  out  NUM_CH  one-cycle strobe when dout goes 1->0.
glitch_cnt  out  NUM_CH*GLITCH_CNT_W  channel i at bits [i*W +: W]; rejected-pulse count.

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset, checked on a clk edge with rst=1: sync flops and dout = RST_VAL; rise = fall = 0; glitch_cnt = 0; FSM = STABLE; qualifier cnt = 0. rst overrides every other input.
- Synchroniser: s = last flop of the SYNC_STAGES chain. s reflects din SYNC_STAGES edges after din is first sampled.
- Per-channel FSM, states STABLE and QUALIFY:
  - STABLE, s == dout: hold.
  - STABLE, s != dout, symmetric mode (mode=0), or mode=1 with s != ASSERT_LVL: go to QUALIFY, cnt = 1.
  - STABLE, s != dout, mode=1, s == ASSERT_LVL: dout <= s on this edge (fast assert). Latency SYNC_STAGES+1 edges from sampling.
  - QUALIFY, s == dout: rejected glitch. Go to STABLE, cnt = 0, glitch_cnt++.
  - QUALIFY, s != dout, cnt == FILT_CYCLES-1: dout <= s, go to STABLE, cnt = 0.
  - QUALIFY, otherwise: cnt++.
- Filtered latency: dout changes SYNC_STAGES+FILT_CYCLES edges after din is first sampled at the new level.
  - A synchronous pulse held exactly FILT_CYCLES cycles passes.
  - A pulse held FILT_CYCLES-1 cycles is rejected and counted.
- mode is read only in STABLE. A mode change during QUALIFY takes effect after that qualification ends.
- rise/fall: registered, high exactly the one cycle after dout changes, never both high at once. No strobes on reset entry or exit.
- glitch_cnt:
  - Saturates at all-ones and holds.
  - glitch_clr=1 zeroes all counters on that edge. Clear wins over a coincident increment.
- Reset during QUALIFY aborts qualification: no dout change, no count, no strobe.
- Qualifier counter width is $clog2(FILT_CYCLES). It never exceeds FILT_CYCLES-1.
- Channels are fully independent. Simultaneous events on different channels do not interact.

Decomposition:
- glitch_filter_pkg holds: state enum (ST_STABLE, ST_QUALIFY), mode constants (MODE_SYM=0, MODE_FAST=1), and a width helper for the qualifier counter.
- Sub-module glitch_filter_ch: one channel (synchroniser, FSM, strobes, counter).
- Top level glitch_filter_multi instantiates NUM_CH copies in a generate loop and packs glitch_cnt.

Test Plan:
1. rst=1 for 3 cycles with din toggling, defaults -> dout=0, rise=fall=0, all glitch_cnt=0 throughout and on release.
2. mode=0, din[0] high for 3 cycles -> dout[0] stays 0, no rise, glitch_cnt[0]=1. Then din[0] high and held -> dout[0]=1 at edge 6 after first sample, rise[0] one cycle. Then din[0] low 4 cycles -> dout[0]=0 six edges later, fall[0] pulses.
3. ch1 with RST_VAL=1, ASSERT_LVL=0, mode=1: din[1] low for 1 cycle -> dout[1]=0 at edge 3, fall[1] pulses. din[1] back high -> dout[1] returns to 1 only after 4 stable cycles. A 2-cycle high blip -> rejected, glitch_cnt[1]++.
4. 300 rejected 2-cycle pulses on ch2 with GLITCH_CNT_W=8 -> glitch_cnt[2]=255, holds. Other channels' counters unchanged.
5. glitch_clr asserted on the same edge as a rejection on ch3 -> glitch_cnt[3]=0 next cycle. The next rejection -> 1.
6. rst asserted at cnt=2 of a qualification on ch0 -> dout[0]=RST_VAL, no strobe, glitch_cnt[0] unchanged (0), FSM in STABLE after release.
